bit32_1to4demux_buf: RTL and testbench
======================================

// Module: bit32_1to4demux_buf
// PURPOSE
//  Registered 1-to-4 demultiplexer: steers one WIDTH-bit input word to one of four
//  outputs selected by sel, inverse of the 32-bit 4:1 operand mux used in the datapath.
//  Each output has a one-entry holding register and a valid/ready handshake, so a
//  stalled consumer blocks only words addressed to it. Per-output delivered-word counters.
// PARAMETERS
//  WIDTH  32  data width of in and out1..out4
//  CNT_W  8   width of each per-output delivered-word counter
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in         in   WIDTH    input data word
//  sel        in   2        destination: 00->out1, 01->out2, 10->out3, 11->out4
//  in_valid   in   1        in/sel valid this cycle
//  in_ready   out  1        block accepts in/sel this cycle
//  out1..out4 out  WIDTH    output data, one holding register each
//  out_valid  out  4        bit k-1 = outk holds an undelivered word
//  out_ready  in   4        bit k-1 = consumer of outk accepts this cycle
//  cnt1..cnt4 out  CNT_W    words delivered on outk (out_valid & out_ready), wrapping
// BEHAVIOUR
//  - Reset (rst_n low, async): out_valid=0, out1..out4=0, cnt1..cnt4=0; pending words
//    discarded. in_ready=0 while rst_n low. Reset mid-transfer: no word survives.
//  - Input accept: acc = in_valid & in_ready.
//    in_ready = ~out_valid[sel] | out_ready[sel] (combinational; slot empty or draining).
//  - Latency: word accepted at edge N appears on out<sel+1> with out_valid set after
//    edge N (visible cycle N+1). No pass-through from in to out data.
//  - Output slot k, per edge, in priority order:
//      acc & sel==k           : outk<=in, out_valid[k]<=1 (covers reload while draining)
//      out_valid[k]&out_ready[k]: out_valid[k]<=0, outk holds value
//      otherwise              : hold
//  - outk stable while out_valid[k]=1 and out_ready[k]=0. When empty, outk keeps last
//    delivered value (not cleared); consumers qualify with out_valid only.
//  - Slots are independent: a stalled outk never blocks a word for another output;
//    words to different outputs may be accepted on consecutive cycles; one accept/cycle.
//  - in_valid=0: sel and in ignored, no slot updated by the input path.
//  - cntk += 1 on each edge with out_valid[k]&out_ready[k]; wraps 2^CNT_W-1 -> 0, no flag.
//  - out_ready[k] with out_valid[k]=0: no effect, counter unchanged.
//  - Full-rate: slot k with out_ready[k] held 1 sustains one word per cycle to outk.
//  - No X propagation: sel fully decoded, all four codes legal.
// TESTING
//  1 Reset: rst_n=0 mid-stream with out_valid=4'b0101 -> out_valid=0, outs=0, cnts=0
//    immediately (async); in_ready=0 until rst_n=1.
//  2 Steer: in=32'hDEADBEEF sel=2'b10 in_valid=1, out_ready=4'hF -> next cycle
//    out3=32'hDEADBEEF, out_valid=4'b0100; following edge cnt3=1, out_valid=0.
//  3 Backpressure: out_ready[0]=0, send A5A5A5A5 then 12345678 both sel=00 ->
//    in_ready=0 on second word; out1 stays A5A5A5A5; raise out_ready[0] -> 12345678
//    accepted same cycle, appears next cycle, cnt1=1 then 2.
//  4 Isolation: out2 stalled full; words sel=00,10,11 back-to-back -> all accepted one
//    per cycle, out_valid=4'b1111, out2 data unchanged.
//  5 Reload-while-draining: out_valid[3]=1, out_ready[3]=1, new word sel=11 same cycle
//    -> out_valid[3] stays 1, out4 = new word, cnt4 +1.
//  6 Wrap: 256 deliveries on out1 with CNT_W=8 -> cnt1 goes 255->0, out_valid clean.

Source files
------------

// File: rtl/bit32_1to4demux_buf_if.sv
// Handshake bundle for the registered 1-to-4 demultiplexer: one input channel,
// four buffered output channels with per-output delivered-word counters.
interface bit32_1to4demux_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] in;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cnt3;
    logic [CNT_W-1:0] cnt4;

    // Producer and consumers together form the master side.
    modport master (
        output in, sel, in_valid, out_ready,
        input  in_ready, out1, out2, out3, out4, out_valid, cnt1, cnt2, cnt3, cnt4
    );

    modport slave (
        input  in, sel, in_valid, out_ready,
        output in_ready, out1, out2, out3, out4, out_valid, cnt1, cnt2, cnt3, cnt4
    );
endinterface

// File: rtl/bit32_1to4demux_buf.sv
// Registered 1-to-4 demultiplexer: each output owns a one-entry holding register with
// valid/ready, so a stalled consumer blocks only words addressed to it.
module bit32_1to4demux_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    bit32_1to4demux_buf_if.slave   bus
);
    logic [WIDTH-1:0] data_q [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [3:0]       valid_q;
    logic [3:0]       deliver;
    logic             acc;

    // A slot accepts when empty or being drained in the same cycle.
    assign bus.in_ready = rst_n & (~valid_q[bus.sel] | bus.out_ready[bus.sel]);
    assign acc          = bus.in_valid & bus.in_ready;
    assign deliver      = valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && (bus.sel == 2'(k))) begin
                    data_q[k]  <= bus.in;
                    valid_q[k] <= 1'b1;
                end else if (deliver[k]) begin
                    valid_q[k] <= 1'b0;
                end
                if (deliver[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out1      = data_q[0];
    assign bus.out2      = data_q[1];
    assign bus.out3      = data_q[2];
    assign bus.out4      = data_q[3];
    assign bus.out_valid = valid_q;
    assign bus.cnt1      = cnt_q[0];
    assign bus.cnt2      = cnt_q[1];
    assign bus.cnt3      = cnt_q[2];
    assign bus.cnt4      = cnt_q[3];
endmodule

// File: tb/tb_bit32_1to4demux_buf.sv
// Directed self-checking bench for bit32_1to4demux_buf: steering, backpressure,
// slot isolation, reload-while-draining, counter wrap and asynchronous reset.
module tb_bit32_1to4demux_buf;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bit32_1to4demux_buf_if #(.WIDTH(32), .CNT_W(8)) bus ();

    bit32_1to4demux_buf #(.WIDTH(32), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] data, input logic [1:0] s);
        bus.in       = data;
        bus.sel      = s;
        bus.in_valid = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in        = '0;
        bus.sel       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;

        // Power-on reset
        #12;
        check("por_in_ready", 32'(bus.in_ready), 32'd0);
        check("por_out_valid", 32'(bus.out_valid), 32'd0);
        check("por_out1", bus.out1, 32'd0);
        check("por_cnt1", 32'(bus.cnt1), 32'd0);
        rst_n = 1'b1;
        step();

        // Steer to out3
        send(32'hDEADBEEF, 2'b10);
        #1 check("steer_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("steer_out3", bus.out3, 32'hDEADBEEF);
        check("steer_valid", 32'(bus.out_valid), 32'h4);
        check("steer_cnt3_0", 32'(bus.cnt3), 32'd0);
        step();
        check("steer_cnt3_1", 32'(bus.cnt3), 32'd1);
        check("steer_valid_clr", 32'(bus.out_valid), 32'h0);

        // Backpressure on out1
        bus.out_ready = 4'b1110;
        send(32'hA5A5A5A5, 2'b00);
        #1 check("bp_ready_first", 32'(bus.in_ready), 32'd1);
        step();
        send(32'h12345678, 2'b00);
        #1 check("bp_ready_blocked", 32'(bus.in_ready), 32'd0);
        check("bp_out1_held", bus.out1, 32'hA5A5A5A5);
        check("bp_valid", 32'(bus.out_valid), 32'h1);
        step();
        check("bp_out1_still", bus.out1, 32'hA5A5A5A5);
        check("bp_cnt1_stall", 32'(bus.cnt1), 32'd0);
        bus.out_ready = 4'hF;
        #1 check("bp_ready_drain", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_out1_new", bus.out1, 32'h12345678);
        check("bp_valid_new", 32'(bus.out_valid), 32'h1);
        check("bp_cnt1_1", 32'(bus.cnt1), 32'd1);
        step();
        check("bp_cnt1_2", 32'(bus.cnt1), 32'd2);
        check("bp_valid_clr", 32'(bus.out_valid), 32'h0);

        // Isolation: out2 stalled full, other slots fill back-to-back
        bus.out_ready = 4'b0000;
        send(32'hCAFE0002, 2'b01);
        step();
        send(32'h11111111, 2'b00);
        #1 check("iso_ready_0", 32'(bus.in_ready), 32'd1);
        step();
        send(32'h33333333, 2'b10);
        #1 check("iso_ready_2", 32'(bus.in_ready), 32'd1);
        step();
        send(32'h44444444, 2'b11);
        #1 check("iso_ready_3", 32'(bus.in_ready), 32'd1);
        step();
        send(32'h22222222, 2'b01);
        #1 check("iso_ready_blocked", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        check("iso_valid", 32'(bus.out_valid), 32'hF);
        check("iso_out2", bus.out2, 32'hCAFE0002);
        check("iso_out1", bus.out1, 32'h11111111);
        check("iso_out3", bus.out3, 32'h33333333);
        check("iso_out4", bus.out4, 32'h44444444);
        step();
        check("iso_out2_hold", bus.out2, 32'hCAFE0002);

        // Reload-while-draining on out4
        bus.out_ready = 4'b1000;
        send(32'h55555555, 2'b11);
        #1 check("rl_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("rl_valid", 32'(bus.out_valid), 32'hF);
        check("rl_out4", bus.out4, 32'h55555555);
        check("rl_cnt4_1", 32'(bus.cnt4), 32'd1);
        step();
        check("rl_valid_clr", 32'(bus.out_valid), 32'h7);
        check("rl_cnt4_2", 32'(bus.cnt4), 32'd2);

        // Drain everything
        bus.out_ready = 4'hF;
        step();
        check("drain_valid", 32'(bus.out_valid), 32'h0);
        check("drain_cnt1", 32'(bus.cnt1), 32'd3);
        check("drain_cnt2", 32'(bus.cnt2), 32'd1);
        check("drain_cnt3", 32'(bus.cnt3), 32'd2);
        check("drain_cnt4", 32'(bus.cnt4), 32'd2);

        // Full-rate stream of 256 words on out1; cnt1 wraps 255 -> 0
        bus.out_ready = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            send(32'(i), 2'b00);
            #1 check("wrap_ready", 32'(bus.in_ready), 32'd1);
            step();
            check("wrap_out1", bus.out1, 32'(i));
            check("wrap_cnt1", 32'(bus.cnt1), (32'd3 + 32'(i)) % 32'd256);
        end
        bus.in_valid = 1'b0;
        step();
        check("wrap_cnt1_end", 32'(bus.cnt1), 32'd3);
        check("wrap_valid_end", 32'(bus.out_valid), 32'h0);
        check("wrap_out1_end", bus.out1, 32'd255);

        // Asynchronous reset with out_valid = 0101
        bus.out_ready = 4'b0000;
        send(32'h0BADF00D, 2'b00);
        step();
        send(32'h0D15EA5E, 2'b10);
        step();
        check("rst_pre_valid", 32'(bus.out_valid), 32'h5);
        bus.out_ready = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out1", bus.out1, 32'd0);
        check("rst_out3", bus.out3, 32'd0);
        check("rst_cnt1", 32'(bus.cnt1), 32'd0);
        check("rst_cnt3", 32'(bus.cnt3), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("rst_hold_valid", 32'(bus.out_valid), 32'h0);
        check("rst_hold_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_release_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        step();
        check("rst_post_valid", 32'(bus.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
